// File: rtl/ascii_bcd_decoder_if.sv
// Character-stream handshake between an ASCII source and the BCD decoder.
`timescale 1ns/1ps
interface ascii_bcd_decoder_if;
    logic [7:0] char_i;
    logic       char_valid_i;
    logic       char_ready_o;

    modport master (
        output char_i,
        output char_valid_i,
        input  char_ready_o
    );

    modport slave (
        input  char_i,
        input  char_valid_i,
        output char_ready_o
    );
endinterface

// File: rtl/ascii_bcd_decoder.sv
// ASCII-to-BCD decoder: collects up to three digits, commits them on CR/space.
// Optional idle timeout inside a partial number is enabled with DEC_TIMEOUT_EN.
`timescale 1ns/1ps
module ascii_bcd_decoder #(
    parameter logic [7:0] TERM_CHAR      = 8'h0D,
    parameter logic [7:0] SEP_CHAR       = 8'h20,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic                 clk,
    input  logic                 reset,
    ascii_bcd_decoder_if.slave   ch,
    output logic [3:0]           out_BCD1,
    output logic [3:0]           out_BCD2,
    output logic [3:0]           out_BCD3,
    output logic [1:0]           num_digits_o,
    output logic                 num_valid_o,
    output logic                 err_o,
    output logic                 busy_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_COMMIT,
        S_DISCARD
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  w_reg      [3];
    logic [3:0]  w_next     [3];
    logic [3:0]  bcd_reg    [3];
    logic [3:0]  bcd_next   [3];
    logic [1:0]  cnt_reg, cnt_next;
    logic [1:0]  digits_reg, digits_next;
    logic        num_valid_reg, num_valid_next;
    logic        err_reg, err_next;

    logic        ready;
    logic        accept;
    logic        is_digit;
    logic        is_term;
    logic        timeout_hit;

    assign ready    = (state_reg != S_COMMIT);
    assign accept   = ch.char_valid_i && ready;
    assign is_digit = (ch.char_i >= 8'h30) && (ch.char_i <= 8'h39);
    assign is_term  = (ch.char_i == TERM_CHAR) || (ch.char_i == SEP_CHAR);

`ifdef DEC_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMR_W-1:0] timer_reg, timer_next;

    // Counts idle ACCUM cycles; the edge that would bring it to TIMEOUT_CYCLES aborts the number.
    always_comb begin
        timer_next = '0;
        if (state_reg == S_ACCUM && !accept) begin
            timer_next = (timer_reg == TMR_W'(TIMEOUT_CYCLES)) ? timer_reg : timer_reg + 1'b1;
        end
    end

    assign timeout_hit = (state_reg == S_ACCUM) && !accept
                         && (timer_reg == TMR_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_reg <= '0;
        end else begin
            timer_reg <= timer_next;
        end
    end
`else
    assign timeout_hit = 1'b0;

    // TIMEOUT_CYCLES is kept so both builds share one parameter list.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
    end
`endif

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        digits_next    = digits_reg;
        num_valid_next = 1'b0;
        err_next       = 1'b0;
        for (int i = 0; i < 3; i++) begin
            w_next[i]   = w_reg[i];
            bcd_next[i] = bcd_reg[i];
        end

        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    if (is_digit) begin
                        w_next[2]  = 4'd0;
                        w_next[1]  = 4'd0;
                        w_next[0]  = ch.char_i[3:0];
                        cnt_next   = 2'd1;
                        state_next = S_ACCUM;
                    end else if (!is_term) begin
                        err_next   = 1'b1;
                        state_next = S_DISCARD;
                    end
                end
            end

            S_ACCUM: begin
                if (accept) begin
                    if (is_digit) begin
                        if (cnt_reg != 2'd3) begin
                            w_next[2] = w_reg[1];
                            w_next[1] = w_reg[0];
                            w_next[0] = ch.char_i[3:0];
                            cnt_next  = cnt_reg + 2'd1;
                        end else begin
                            err_next   = 1'b1;
                            state_next = S_DISCARD;
                        end
                    end else if (is_term) begin
                        state_next = S_COMMIT;
                    end else begin
                        err_next   = 1'b1;
                        state_next = S_DISCARD;
                    end
                end else if (timeout_hit) begin
                    for (int i = 0; i < 3; i++) begin
                        w_next[i] = 4'd0;
                    end
                    cnt_next   = 2'd0;
                    err_next   = 1'b1;
                    state_next = S_IDLE;
                end
            end

            S_COMMIT: begin
                for (int i = 0; i < 3; i++) begin
                    bcd_next[i] = w_reg[i];
                    w_next[i]   = 4'd0;
                end
                digits_next    = cnt_reg;
                num_valid_next = 1'b1;
                cnt_next       = 2'd0;
                state_next     = S_IDLE;
            end

            S_DISCARD: begin
                if (accept && is_term) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= 2'd0;
            digits_reg    <= 2'd0;
            num_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                w_reg[i]   <= 4'd0;
                bcd_reg[i] <= 4'd0;
            end
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            digits_reg    <= digits_next;
            num_valid_reg <= num_valid_next;
            err_reg       <= err_next;
            for (int i = 0; i < 3; i++) begin
                w_reg[i]   <= w_next[i];
                bcd_reg[i] <= bcd_next[i];
            end
        end
    end

    logic [3:0] bcd_out [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_bcd_out
        assign bcd_out[gi] = bcd_reg[gi];
    end

    assign out_BCD1        = bcd_out[0];
    assign out_BCD2        = bcd_out[1];
    assign out_BCD3        = bcd_out[2];
    assign num_digits_o    = digits_reg;
    assign num_valid_o     = num_valid_reg;
    assign err_o           = err_reg;
    assign busy_o          = (state_reg != S_IDLE);
    assign ch.char_ready_o = ready;

endmodule

// File: doc/ascii_bcd_decoder.md
Name: ascii_bcd_decoder

Overview:
- Receives an ASCII character stream, e.g. keypad/UART text destined for the LCD path, one byte per valid/ready handshake.
- Accumulates up to three decimal digits and, on a terminator, commits them as three BCD nibbles with a one-cycle strobe.
- Inverse of the LCD digit encoder: turns ASCII '0'..'9' back into BCD, with framing, overflow and error handling.

Parameters:
- TERM_CHAR, 8'h0D, primary terminator (CR).
- SEP_CHAR, 8'h20, secondary terminator (space); behaves identically to TERM_CHAR.
- TIMEOUT_CYCLES, 1000000, idle-cycle limit inside a partial number; used only with DEC_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- char_i  in  8  ASCII character.
- char_valid_i  in  1  char_i valid.
- char_ready_o  out  1  block can accept char_i this cycle.
- out_BCD1  out  4  committed units digit.
- out_BCD2  out  4  committed tens digit.
- out_BCD3  out  4  committed hundreds digit.
- num_digits_o  out  2  digit count of last committed number (1..3).
- num_valid_o  out  1  one-cycle pulse: new number committed.
- err_o  out  1  one-cycle pulse: invalid char, overflow or timeout.
- busy_o  out  1  high while a partial number or a discard is in progress.

Behaviour:
- Reset: one clock, synchronous, active-high. While reset is high on a clock edge, all outputs are cleared.
  - out_BCD1/2/3 = 0, num_digits_o = 0, num_valid_o = 0, err_o = 0, busy_o = 0.
  - char_ready_o = 1 in the first cycle after reset.
  - State goes to IDLE; the working register and digit count clear.
  - Reset mid-number drops the partial number with no strobe.
- Accept: a character is taken on any cycle where char_valid_i && char_ready_o. char_ready_o is 1 in all states except COMMIT.
- Classification of an accepted char:
  - digit: 0x30..0x39, value = char_i[3:0].
  - terminator: TERM_CHAR or SEP_CHAR.
  - anything else: invalid.
- Working register: three nibbles w3:w2:w1 plus a count cnt (0..3). On each accepted digit: w3<=w2, w2<=w1, w1<=value, cnt<=cnt+1.
- States:
  - IDLE (busy_o=0): digit -> load, cnt=1, go to ACCUM. Terminator -> ignored, stay in IDLE, no strobe. Invalid -> err pulse, go to DISCARD.
  - ACCUM (busy_o=1):
    - digit with cnt<3 -> shift in, stay.
    - digit with cnt==3 -> overflow: err pulse, go to DISCARD.
    - terminator -> go to COMMIT.
    - invalid -> err pulse, go to DISCARD.
  - COMMIT (one cycle, char_ready_o=0, busy_o=1):
    - out_BCD1<=w1, out_BCD2<=w2, out_BCD3<=w3.
    - Unused upper nibbles are 0, because w clears on entering ACCUM from IDLE.
    - num_digits_o<=cnt, num_valid_o=1 on the following cycle.
    - Working register clears; go to IDLE.
  - DISCARD (busy_o=1): digits and invalid chars are dropped with no further err pulses. A terminator returns to IDLE with no commit.
- Latency:
  - num_valid_o and the new out_BCD values appear in the cycle after COMMIT, i.e. 2 cycles after the terminator is accepted.
  - err_o is high in the cycle after the offending accept.
- Output holding: out_BCD*, num_digits_o hold the last committed value until the next commit. Errors never modify them.
- Back-to-back: a char presented during COMMIT waits (ready low). A char accepted in the cycle after COMMIT is processed normally from IDLE.
- Strobes: num_valid_o and err_o are never high in the same cycle.

Optional Feature:
- Macro: DEC_TIMEOUT_EN.
- Defined:
  - A counter runs in ACCUM, resets on every accepted char, and saturates at TIMEOUT_CYCLES.
  - Reaching TIMEOUT_CYCLES clears the working register, pulses err_o, and returns to IDLE (not DISCARD).
  - The counter is inactive in other states.
- Undefined: no counter logic; ACCUM waits indefinitely. TIMEOUT_CYCLES has no effect.

Test Plan:
- After reset, send "4","2",CR back-to-back -> 2 cycles after CR: num_valid_o pulse, out_BCD1=2, out_BCD2=4, out_BCD3=0, num_digits_o=2, err_o never high.
- Send "9","0","7",SP, then "1",CR with char_valid_i held high -> first commit BCD3..1 = 9,0,7 with num_digits_o=3. char_ready_o is low exactly one cycle after SP. Second commit gives 0,0,1 with num_digits_o=1.
- Send "1","2","3","4","5",CR -> err_o single pulse after "4"; no num_valid_o. Outputs keep the previous value; busy_o drops after CR.
- Send "7","A","8",CR, then "5",CR -> one err_o pulse after "A", no commit for the first frame. The next frame commits 0,0,5.
- CR alone in IDLE; reset asserted between "6" and CR -> no strobes, no error. After reset all outputs are 0 and a following "3",CR commits 0,0,3.
- DEC_TIMEOUT_EN, TIMEOUT_CYCLES=16: send "5", then idle 16 cycles -> err_o pulse and busy_o=0. A following "8",CR commits 0,0,8. The same stimulus without the macro instead commits 0,5,8.
